// File: rtl/render_pixel_scheduler.sv
// render_pixel_scheduler: raster-order pixel coordinate source with credit tracking.
// Optional in-order return checking is enabled by defining RENDER_SCHED_ORDER_CHECK_EN.
module render_pixel_scheduler #(
  parameter int H_ACTIVE        = 320,
  parameter int V_ACTIVE        = 180,
  parameter int MAX_OUTSTANDING = 340,
  localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          start,
  input  logic [1:0]    cfg_select_objs,
  output logic [10:0]   hcount_axis_tdata,
  output logic          hcount_axis_tvalid,
  input  logic          hcount_axis_tready,
  output logic [9:0]    vcount_axis_tdata,
  output logic          vcount_axis_tvalid,
  input  logic          vcount_axis_tready,
  output logic [1:0]    select_objs,
  input  logic          pixel_axis_tvalid,
  output logic          pixel_axis_tready,
  input  logic [10:0]   hcount_ret,
  input  logic [9:0]    vcount_ret,
  output logic          busy,
  output logic          frame_done,
  output logic [OW-1:0] outstanding,
  output logic          order_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [10:0]   H_LAST  = 11'(H_ACTIVE - 1);
  localparam logic [9:0]    V_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [OW-1:0] CREDITS = OW'(MAX_OUTSTANDING);

  state_t        state_q, state_d;
  logic [10:0]   hc_q, hc_d;
  logic [9:0]    vc_q, vc_d;
  logic          tvalid_q, tvalid_d;
  logic [1:0]    sel_q, sel_d;
  logic [OW-1:0] out_q, out_d;
  logic          rdy_q;

  logic issue_fire;
  logic ret_fire;
  logic stray;
  logic last_beat;
  logic credit_ok;

  // Handshake qualifiers and in-flight credit arithmetic
  always_comb begin
    issue_fire = tvalid_q & hcount_axis_tready & vcount_axis_tready;
    ret_fire   = pixel_axis_tvalid & rdy_q;
    stray      = ret_fire & (out_q == '0);
    last_beat  = (hc_q == H_LAST) & (vc_q == V_LAST);
    out_d      = out_q;
    if (issue_fire & ~(ret_fire & ~stray))
      out_d = out_q + OW'(1);
    else if (~issue_fire & ret_fire & ~stray)
      out_d = out_q - OW'(1);
    // A new beat is raised only if it cannot push the count past the limit
    credit_ok = out_d < CREDITS;
  end

  // Frame sequencing and raster coordinate generation
  always_comb begin
    state_d  = state_q;
    hc_d     = hc_q;
    vc_d     = vc_q;
    tvalid_d = tvalid_q;
    sel_d    = sel_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_d    = cfg_select_objs;
          hc_d     = '0;
          vc_d     = '0;
          tvalid_d = credit_ok;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue_fire) begin
          if (last_beat) begin
            tvalid_d = 1'b0;
            state_d  = S_DRAIN;
          end else begin
            if (hc_q == H_LAST) begin
              hc_d = '0;
              vc_d = vc_q + 10'd1;
            end else begin
              hc_d = hc_q + 11'd1;
            end
            tvalid_d = credit_ok;
          end
        end else if (!tvalid_q) begin
          tvalid_d = credit_ok;
        end
      end
      S_DRAIN: begin
        if (out_q == '0)
          state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, beat and credit registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= S_IDLE;
      hc_q     <= '0;
      vc_q     <= '0;
      tvalid_q <= 1'b0;
      sel_q    <= '0;
      out_q    <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      tvalid_q <= tvalid_d;
      sel_q    <= sel_d;
      out_q    <= out_d;
      rdy_q    <= 1'b1;
    end
  end

`ifdef RENDER_SCHED_ORDER_CHECK_EN
  logic [10:0] ex_h_q, ex_h_d;
  logic [9:0]  ex_v_q, ex_v_d;
  logic        err_q, err_d;

  // Expected return coordinate and sticky mismatch flag
  always_comb begin
    ex_h_d = ex_h_q;
    ex_v_d = ex_v_q;
    err_d  = err_q;
    if (state_q == S_IDLE && start) begin
      ex_h_d = '0;
      ex_v_d = '0;
    end else if (ret_fire && !stray) begin
      if (ex_h_q == H_LAST) begin
        ex_h_d = '0;
        ex_v_d = (ex_v_q == V_LAST) ? '0 : ex_v_q + 10'd1;
      end else begin
        ex_h_d = ex_h_q + 11'd1;
      end
    end
    if (ret_fire &&
        (stray || hcount_ret != ex_h_q || vcount_ret != ex_v_q))
      err_d = 1'b1;
  end

  // Order-check registers, cleared only by reset
  always_ff @(posedge aclk) begin
    if (areset) begin
      ex_h_q <= '0;
      ex_v_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ex_h_q <= ex_h_d;
      ex_v_q <= ex_v_d;
      err_q  <= err_d;
    end
  end

  assign order_error = err_q;
`else
  logic unused_ret;
  assign unused_ret  = ^{hcount_ret, vcount_ret};
  assign order_error = 1'b0;
`endif

  assign hcount_axis_tdata  = hc_q;
  assign vcount_axis_tdata  = vc_q;
  assign hcount_axis_tvalid = tvalid_q;
  assign vcount_axis_tvalid = tvalid_q;
  assign select_objs        = sel_q;
  assign pixel_axis_tready  = rdy_q;
  assign busy               = (state_q != S_IDLE);
  assign frame_done         = (state_q == S_DONE);
  assign outstanding        = out_q;

endmodule

// File: tb/tb_render_pixel_scheduler.sv
// tb_render_pixel_scheduler: scoreboard bench, 4x2 frame, 3 credits.
// Beats and frame completions are predicted at start and checked by a monitor.
module tb_render_pixel_scheduler;
  localparam int H = 4;
  localparam int V = 2;
  localparam int M = 3;
`ifdef RENDER_SCHED_ORDER_CHECK_EN
  localparam bit ORDER_EN = 1'b1;
`else
  localparam bit ORDER_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        areset, start;
  logic [1:0]  cfg;
  logic [10:0] hd;
  logic        hv, hr;
  logic [9:0]  vd;
  logic        vv, vr;
  logic [1:0]  sel;
  logic        pix_v, pix_rdy;
  logic [10:0] hret;
  logic [9:0]  vret;
  logic        busy, fdone;
  logic [1:0]  out;
  logic        oerr;

  render_pixel_scheduler #(
    .H_ACTIVE(H), .V_ACTIVE(V), .MAX_OUTSTANDING(M)
  ) dut (
    .aclk(clk), .areset(areset), .start(start),
    .cfg_select_objs(cfg),
    .hcount_axis_tdata(hd), .hcount_axis_tvalid(hv),
    .hcount_axis_tready(hr),
    .vcount_axis_tdata(vd), .vcount_axis_tvalid(vv),
    .vcount_axis_tready(vr),
    .select_objs(sel),
    .pixel_axis_tvalid(pix_v), .pixel_axis_tready(pix_rdy),
    .hcount_ret(hret), .vcount_ret(vret),
    .busy(busy), .frame_done(fdone),
    .outstanding(out), .order_error(oerr)
  );

  typedef struct {
    int h;
    int v;
    int due;
  } beat_t;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int peak = 0;
  beat_t exp_beats[$];
  beat_t inflight[$];
  int exp_done[$];
  logic [1:0] exp_sel = 2'b00;
  bit ret_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ret_en) begin
      if (inflight.size() > 0 && inflight[0].due <= cyc) begin
        pix_v = 1'b1;
        hret  = 11'(inflight[0].h);
        vret  = 10'(inflight[0].v);
        void'(inflight.pop_front());
      end else begin
        pix_v = 1'b0;
      end
    end
  endtask

  task automatic ret_manual(int h, int v);
    pix_v = 1'b1;
    hret  = 11'(h);
    vret  = 10'(v);
    tick();
    pix_v = 1'b0;
  endtask

  task automatic start_frame(logic [1:0] s);
    beat_t b;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        b.h = x;
        b.v = y;
        b.due = 0;
        exp_beats.push_back(b);
      end
    exp_sel = s;
    exp_done.push_back(1);
    cfg   = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg   = ~s;
    check("first_valid", 32'(hv), 32'd1);
  endtask

  task automatic wait_done(int target, int budget);
    int i;
    i = 0;
    while (done_cnt < target && i < budget) begin
      tick();
      if (int'(out) > peak) peak = int'(out);
      i++;
    end
    if (done_cnt < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL frame_timeout: got %0d frames expected %0d",
               done_cnt, target);
    end
  endtask

  // Monitor: pops predicted beats on each transfer, checks holds and frame ends
  initial begin : mon
    bit pv;
    bit fire;
    logic [10:0] ph;
    logic [9:0] pvd;
    beat_t b;
    pv = 1'b0;
    ph = '0;
    pvd = '0;
    forever begin
      @(negedge clk);
      if (areset) begin
        pv = 1'b0;
        continue;
      end
      if (pv) begin
        check("hold_valid", 32'(hv), 32'd1);
        check("hold_data", 32'({hd, vd}), 32'({ph, pvd}));
      end
      if (hv || vv)
        check("valid_pair", 32'(vv), 32'(hv));
      fire = hv & hr & vr;
      pv  = hv & ~fire;
      ph  = hd;
      pvd = vd;
      if (fire) begin
        if (exp_beats.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_beat: got (%0d,%0d) expected none", hd, vd);
        end else begin
          b = exp_beats.pop_front();
          check("beat_h", 32'(hd), 32'(b.h));
          check("beat_v", 32'(vd), 32'(b.v));
          check("beat_sel", 32'(sel), 32'(exp_sel));
        end
        check("credit_room", 32'(int'(out) < M), 32'd1);
        b.h = int'(hd);
        b.v = int'(vd);
        b.due = cyc + 5;
        inflight.push_back(b);
      end
      if (fdone) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got frame_done expected none");
        end else begin
          void'(exp_done.pop_front());
          check("done_all_issued", 32'(exp_beats.size()), 32'd0);
          check("done_inflight", 32'(inflight.size()), 32'd0);
          check("done_busy", 32'(busy), 32'd1);
          check("done_outstanding", 32'(out), 32'd0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    int d0;
    areset = 1'b1;
    start  = 1'b0;
    cfg    = 2'b00;
    hr     = 1'b1;
    vr     = 1'b1;
    pix_v  = 1'b0;
    hret   = '0;
    vret   = '0;
    repeat (3) tick();
    check("rst_hvalid", 32'(hv), 32'd0);
    check("rst_vvalid", 32'(vv), 32'd0);
    check("rst_data", 32'({hd, vd}), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_pix_rdy", 32'(pix_rdy), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(fdone), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_oerr", 32'(oerr), 32'd0);
    areset = 1'b0;
    tick();
    check("rdy_after_rst", 32'(pix_rdy), 32'd1);

    // basic frame
    peak = 0;
    start_frame(2'b10);
    wait_done(1, 200);
    check("peak_outstanding", 32'(peak), 32'd3);
    check("idle_after_done", 32'(busy), 32'd0);
    check("basic_oerr", 32'(oerr), 32'd0);

    // backpressure on beat (1,0)
    start_frame(2'b01);
    for (int i = 0; i < 20; i++) begin
      if (hv && hd == 11'd1) break;
      tick();
    end
    check("bp_seen", 32'(hv && hd == 11'd1), 32'd1);
    hr = 1'b0;
    repeat (4) begin
      tick();
      check("bp_valid", 32'(hv), 32'd1);
      check("bp_beat", 32'({hd, vd}), 32'({11'd1, 10'd0}));
    end
    hr = 1'b1;
    vr = 1'b0;
    tick();
    check("bp_vready_hold", 32'(hd), 32'd1);
    vr = 1'b1;
    wait_done(2, 200);

    // credit stall
    ret_en = 1'b0;
    start_frame(2'b11);
    repeat (8) tick();
    check("stall_valid", 32'(hv), 32'd0);
    check("stall_out", 32'(out), 32'd3);
    check("stall_issued", 32'(8 - exp_beats.size()), 32'd3);
    b = inflight.pop_front();
    ret_manual(b.h, b.v);
    repeat (5) tick();
    check("one_more_issued", 32'(8 - exp_beats.size()), 32'd4);
    check("stall_out2", 32'(out), 32'd3);
    check("stall_valid2", 32'(hv), 32'd0);
    b = inflight.pop_front();
    ret_manual(b.h, b.v);
    check("regain_valid", 32'(hv), 32'd1);
    check("regain_out", 32'(out), 32'd2);
    b = inflight.pop_front();
    ret_manual(b.h, b.v);
    check("same_cycle_out", 32'(out), 32'd2);
    check("same_cycle_issued", 32'(8 - exp_beats.size()), 32'd5);
    tick();
    check("refill_out", 32'(out), 32'd3);
    check("refill_valid", 32'(hv), 32'd0);
    ret_en = 1'b1;
    wait_done(3, 200);

    // out-of-order return
    ret_en = 1'b0;
    start_frame(2'b00);
    repeat (6) tick();
    check("order_setup", 32'(inflight.size()), 32'd3);
    b = inflight.pop_front();
    ret_manual(b.h, b.v);
    check("order_ok_first", 32'(oerr), 32'd0);
    b = inflight[1];
    inflight.delete(1);
    ret_manual(b.h, b.v);
    check("order_ret_was_20", 32'({11'(b.h), 10'(b.v)}), 32'({11'd2, 10'd0}));
    check("order_err_set", 32'(oerr), 32'(ORDER_EN));
    ret_en = 1'b1;
    wait_done(4, 200);
    check("order_err_sticky", 32'(oerr), 32'(ORDER_EN));

    // stray return in IDLE
    areset = 1'b1;
    tick();
    areset = 1'b0;
    tick();
    check("err_cleared", 32'(oerr), 32'd0);
    ret_en = 1'b0;
    ret_manual(1, 1);
    tick();
    check("stray_out", 32'(out), 32'd0);
    check("stray_err", 32'(oerr), 32'(ORDER_EN));
    check("stray_idle", 32'(busy), 32'd0);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    tick();

    // reset mid-frame
    ret_en = 1'b1;
    start_frame(2'b10);
    for (int i = 0; i < 40; i++) begin
      if (exp_beats.size() <= 3) break;
      tick();
    end
    check("five_issued", 32'(8 - exp_beats.size()), 32'd5);
    ret_en = 1'b0;
    pix_v  = 1'b0;
    areset = 1'b1;
    d0 = done_cnt;
    tick();
    check("mid_rst_valid", 32'(hv), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out", 32'(out), 32'd0);
    check("mid_rst_sel", 32'(sel), 32'd0);
    check("mid_rst_rdy", 32'(pix_rdy), 32'd0);
    check("mid_rst_done", 32'(fdone), 32'd0);
    exp_beats.delete();
    inflight.delete();
    exp_done.delete();
    areset = 1'b0;
    ret_en = 1'b1;
    repeat (10) tick();
    check("no_done_after_rst", 32'(done_cnt), 32'(d0));
    start_frame(2'b01);
    wait_done(d0 + 1, 200);

    // start while draining
    d0 = done_cnt;
    start_frame(2'b11);
    for (int i = 0; i < 100; i++) begin
      if (exp_beats.size() == 0 && busy && !fdone && out != 2'd0) break;
      tick();
    end
    check("in_drain", 32'(exp_beats.size() == 0 && busy && out != 2'd0), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d0 + 1, 200);
    repeat (10) tick();
    check("single_done", 32'(done_cnt), 32'(d0 + 1));
    check("no_restart_busy", 32'(busy), 32'd0);
    check("no_restart_valid", 32'(hv), 32'd0);
    start_frame(2'b00);
    wait_done(d0 + 2, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
